// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// The state enum, op codes and default amount width live here.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam int DEF_AMT_W = 4;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-bit 16-bit shifter: one LSL/LSR/ASR step per use, combinational.
// With SHIFT_SEQ_CARRY_EN defined it also exposes the bit shifted out.
module shift_sequencer_shifter
    import shift_seq_pkg::*;
(
    input  logic [15:0] in,
    input  logic [1:0]  shift,
    output logic [15:0] out
`ifdef SHIFT_SEQ_CARRY_EN
    ,
    output logic        carry
`endif
);

    logic carry_w;

    always_comb begin
        out     = in;
        carry_w = 1'b0;
        case (shift)
            SH_LSL: begin
                out     = {in[14:0], 1'b0};
                carry_w = in[15];
            end
            SH_LSR: begin
                out     = {1'b0, in[15:1]};
                carry_w = in[0];
            end
            SH_ASR: begin
                out     = {in[15], in[15:1]};
                carry_w = in[0];
            end
            default: begin
                out     = in;
                carry_w = 1'b0;
            end
        endcase
    end

`ifdef SHIFT_SEQ_CARRY_EN
    assign carry = carry_w;
`else
    // Bit-shifted-out is only consumed by the carry build.
    logic unused_carry;
    assign unused_carry = carry_w;
`endif

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle controller applying the single-bit shifter `amount` times.
// Optional feature: define SHIFT_SEQ_CARRY_EN to add the cout output.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      value,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result
`ifdef SHIFT_SEQ_CARRY_EN
    ,
    output logic             cout
`endif
);

    state_t           state_q, state_d;
    logic [15:0]      result_q, result_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic [15:0]      shift_out;

`ifdef SHIFT_SEQ_CARRY_EN
    logic cout_q, cout_d;
    logic shift_carry;
`endif

    shift_sequencer_shifter u_shifter (
        .in    (result_q),
        .shift (op_q),
        .out   (shift_out)
`ifdef SHIFT_SEQ_CARRY_EN
        ,
        .carry (shift_carry)
`endif
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        op_d     = op_q;
`ifdef SHIFT_SEQ_CARRY_EN
        cout_d   = cout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    result_d = value;
                    op_d     = op;
                    count_d  = amount;
`ifdef SHIFT_SEQ_CARRY_EN
                    cout_d   = 1'b0;
`endif
                    if ((amount == '0) || (op == SH_NONE)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                result_d = shift_out;
                count_d  = count_q - AMT_W'(1);
`ifdef SHIFT_SEQ_CARRY_EN
                cout_d   = shift_carry;
`endif
                if (count_q == AMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            count_q  <= '0;
            op_q     <= SH_NONE;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            count_q  <= count_d;
            op_q     <= op_d;
        end
    end

`ifdef SHIFT_SEQ_CARRY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cout_q <= 1'b0;
        end else begin
            cout_q <= cout_d;
        end
    end

    assign cout = cout_q;
`endif

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random
// operations against a step-by-step arithmetic reference model.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] value;
    logic [1:0]  op;
    logic [3:0]  amount;
    logic        busy;
    logic        done;
    logic [15:0] result;
`ifdef SHIFT_SEQ_CARRY_EN
    logic        cout;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    shift_sequencer #(.AMT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .value  (value),
        .op     (op),
        .amount (amount),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef SHIFT_SEQ_CARRY_EN
        ,
        .cout   (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {last bit shifted out, final value} after k single steps.
    function automatic logic [16:0] model(input logic [15:0] v, input logic [1:0] o,
                                          input int unsigned k);
        logic [15:0]        r;
        logic signed [15:0] s;
        logic               c;
        r = v;
        c = 1'b0;
        if (o != 2'b00) begin
            for (int unsigned i = 0; i < k; i++) begin
                case (o)
                    2'b01: begin c = r[15]; r = r << 1; end
                    2'b10: begin c = r[0];  r = r >> 1; end
                    default: begin
                        c = r[0];
                        s = r;
                        s = s >>> 1;
                        r = s;
                    end
                endcase
            end
        end
        return {c, r};
    endfunction

    task automatic run_op(input logic [15:0] v, input logic [1:0] o, input logic [3:0] k,
                          input bit stray);
        logic [16:0] m;
        int unsigned lat;
        bit          seen;
        m    = model(v, o, k);
        lat  = (o == 2'b00 || k == 4'd0) ? 1 : k + 1;
        seen = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        value  = v;
        op     = o;
        amount = k;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start  = 1'b0;
            value  = 16'($urandom);
            op     = 2'($urandom);
            amount = 4'($urandom);
            check("busy", 32'(busy), 32'd1);
            if (done) begin
                check("latency", n, lat);
                check("result", 32'(result), 32'(m[15:0]));
`ifdef SHIFT_SEQ_CARRY_EN
                check("cout", 32'(cout), 32'(m[16]));
`endif
                seen = 1'b1;
                break;
            end
            if (n == 1 && stray) start = 1'b1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_hold", 32'(result), 32'(m[15:0]));
`ifdef SHIFT_SEQ_CARRY_EN
        check("idle_cout", 32'(cout), 32'(m[16]));
`endif
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        value  = '0;
        op     = '0;
        amount = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        reset = 1'b0;

        run_op(16'h0001, 2'b01, 4'd4, 1'b0);
        run_op(16'h8000, 2'b11, 4'd3, 1'b0);
        run_op(16'h8000, 2'b10, 4'd15, 1'b0);
        run_op(16'hABCD, 2'b01, 4'd0, 1'b0);
        run_op(16'h1234, 2'b00, 4'd7, 1'b0);
        run_op(16'hFFFF, 2'b01, 4'd15, 1'b0);
        run_op(16'h7FFF, 2'b11, 4'd15, 1'b0);
        run_op(16'h8001, 2'b01, 4'd1, 1'b0);
        run_op(16'h0002, 2'b10, 4'd2, 1'b0);
        run_op(16'h00F0, 2'b10, 4'd6, 1'b1);

        // Abort in the middle of a long shift, off the clock edge.
        @(negedge clk);
        start  = 1'b1;
        value  = 16'h0F0F;
        op     = 2'b01;
        amount = 4'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
`ifdef SHIFT_SEQ_CARRY_EN
        check("abort_cout", 32'(cout), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(done), 32'd0);
        end

        for (int i = 0; i < 200; i++) begin
            run_op(16'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
